uart_vio_bridge: RTL and testbench
==================================

Name: uart_vio_bridge

Overview:
Parametrised virtual-I/O bridge connecting a lab design to a host PC over one 8N1 UART. The host sends frames carrying virtual switch/button states; the block drives them onto o_SWITCH/o_BUTTON and replies with the design's LED and 7-segment state. Channel counts are generic, so the same block serves any board profile (DE1-SoC, RZ-EasyFPGA, ...). It replaces a fixed-width board-specific bridge in each top level.

Parameters:
baud, 9600, UART bit rate
clock, 50000000, i_CLK frequency in Hz; CLKS_PER_BIT = clock/baud (integer division, must be >= 8)
N_SW, 10, virtual switch count (1..32)
N_KEY, 4, virtual button count (1..8)
N_LED, 10, LED inputs reported (0..32)
N_HEX, 6, 7-segment digits reported (0..8)
WDT_CYCLES, 50000000, watchdog timeout in i_CLK cycles (used only with VIO_WATCHDOG_EN)

Ports:
i_CLK  in  1  system clock
i_RST  in  1  synchronous active-high reset
i_RX  in  1  UART receive line, asynchronous, idle high
o_TX  out  1  UART transmit line, idle high
i_LEDS  in  N_LED  LED state to report
i_7S  in  7*N_HEX  segment patterns; digit k occupies bits 7k+6:7k
o_SWITCH  out  N_SW  virtual switches
o_BUTTON  out  N_KEY  virtual buttons, active-low as on board
o_FRAME_OK  out  1  one-cycle pulse per accepted frame
o_FRAME_ERR  out  1  one-cycle pulse per rejected frame

Behaviour:
- One clock, i_CLK. Reset is synchronous, active-high, on i_RST. Reset values: o_SWITCH=0, o_BUTTON=all ones, o_TX=1, o_FRAME_OK=0, o_FRAME_ERR=0; both FSMs idle; pending flag clear. Reset mid-byte aborts the byte; o_TX returns high on the next edge.
- UART RX: 2-FF synchroniser on i_RX. A falling edge starts a byte; start bit re-checked at CLKS_PER_BIT/2 (high -> false start, ignored). Data LSB first, sampled mid-bit. Stop bit low -> framing error: byte discarded, frame FSM to HUNT, o_FRAME_ERR pulse.
- Input vector IN = {KEY, SW} (SW in the low bits). IN_BYTES = ceil((N_SW+N_KEY)/8), little-endian. Pad bits are ignored on RX.
- Host frame: 0xA5, IN_BYTES payload bytes, CHK = XOR of the payload bytes.
- Frame FSM: HUNT (discard bytes until 0xA5) -> PAYLOAD (store into shadow register; 0xA5 here is plain data) -> CHECK.
- CHECK on CHK match: o_SWITCH/o_BUTTON update from the shadow on the cycle after the CHK byte's stop-bit sample. o_FRAME_OK pulses in the same cycle. Reply is requested. Return to HUNT.
- CHECK on mismatch: outputs unchanged, o_FRAME_ERR pulse, return to HUNT.
- Reply: snapshot OUT = {i_7S, i_LEDS} (LEDs in the low bits) in the commit cycle. OUT_BYTES = ceil((N_LED+7*N_HEX)/8), pad bits 0. TX sends 0x5A, OUT bytes little-endian, then XOR of the OUT bytes. Frames are back-to-back with no idle bits between bytes.
- A frame accepted while TX is busy sets the pending flag; multiple such frames coalesce into one. After the current reply, exactly one further reply is sent, snapshotted when that reply starts.
- A reply is never aborted except by reset.

Optional Feature:
VIO_WATCHDOG_EN
- Defined: a counter restarts on every accepted frame. After WDT_CYCLES cycles with no accepted frame, o_BUTTON is forced to all ones (released); o_SWITCH holds its value. The counter saturates, and the next accepted frame resumes normal updates.
- Undefined: no counter is built; outputs hold their last value indefinitely.

Test Plan:
All cases use clock=1000000, baud=100000 (10 cycles/bit) and default channel counts, so IN_BYTES=2 and OUT_BYTES=7.
- Reset check: assert i_RST 3 cycles -> o_SWITCH=0x000, o_BUTTON=0xF, o_TX=1.
- Valid frame: send A5 FF 3F C0 -> o_SWITCH=0x3FF, o_BUTTON=0xF, one o_FRAME_OK pulse. With i_LEDS=0x155 and all i_7S=0x7F, reply is 5A, OUT bytes little-endian of {42'h3FF_FFFF_FFFF, 10'h155}, then XOR. The bench checks all 9 bytes.
- Bad checksum: send A5 12 00 00 -> outputs unchanged, one o_FRAME_ERR pulse, no TX activity.
- Resync and data-0xA5: send 33 A5 A5 00 A5 -> leading 33 is discarded; o_SWITCH=0x0A5, o_BUTTON=0x0.
- Framing error: payload byte with stop bit 0 -> o_FRAME_ERR pulse, FSM in HUNT; a following valid frame is accepted.
- Back-to-back: three valid frames while the first reply is in flight -> exactly 2 replies. With VIO_WATCHDOG_EN and WDT_CYCLES=1000, o_BUTTON=0xF by 1001 cycles after the last frame.

Source files
------------

// File: rtl/uart_vio_bridge.sv
// rtl/uart_vio_bridge.sv - UART virtual-I/O bridge (optional watchdog: VIO_WATCHDOG_EN)
module uart_vio_bridge #(
    parameter int baud       = 9600,
    parameter int clock      = 50000000,
    parameter int N_SW       = 10,
    parameter int N_KEY      = 4,
    parameter int N_LED      = 10,
    parameter int N_HEX      = 6,
    parameter int WDT_CYCLES = 50000000
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_RX,
    output logic                 o_TX,
    input  logic [N_LED-1:0]     i_LEDS,
    input  logic [7*N_HEX-1:0]   i_7S,
    output logic [N_SW-1:0]      o_SWITCH,
    output logic [N_KEY-1:0]     o_BUTTON,
    output logic                 o_FRAME_OK,
    output logic                 o_FRAME_ERR
);
    localparam int CPB       = clock / baud;
    localparam int HALF      = CPB / 2;
    localparam int CW        = $clog2(CPB);
    localparam int IN_W      = N_SW + N_KEY;
    localparam int IN_BYTES  = (IN_W + 7) / 8;
    localparam int OUT_W     = N_LED + 7 * N_HEX;
    localparam int OUT_BYTES = (OUT_W + 7) / 8;
    localparam int IBW       = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
    localparam int OBW       = $clog2(OUT_BYTES + 2);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {F_HUNT, F_PAYLOAD, F_CHECK} fr_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    rx_state_t rx_state, rx_next;
    fr_state_t fr_state, fr_next;
    tx_state_t tx_state, tx_next;

    logic rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_byte;
    logic rx_done, rx_ferr;

    logic [IBW-1:0] fr_idx;
    logic [7:0] fr_chk;
    logic [IN_W-1:0] shadow;
    logic commit, reject;

    logic [CW-1:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [OBW-1:0] tx_idx;
    logic [7:0] tx_shift, tx_chk, tx_sel;
    logic [OUT_BYTES*8-1:0] out_snap;
    logic pending, tx_begin;
    logic tx_bit_end;

    // Two-flop synchroniser plus previous sample for falling-edge detection
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // State registers of the three FSMs
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            rx_state <= R_IDLE;
            fr_state <= F_HUNT;
            tx_state <= T_IDLE;
        end else begin
            rx_state <= rx_next;
            fr_state <= fr_next;
            tx_state <= tx_next;
        end
    end

    // RX next state; stop-bit sample produces either a byte or a framing error
    always_comb begin
        rx_next = rx_state;
        rx_done = 1'b0;
        rx_ferr = 1'b0;
        case (rx_state)
            R_IDLE:  if (rx_prev && !rx_sync) rx_next = R_START;
            R_START: if (rx_cnt == CW'(HALF - 1)) rx_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (rx_cnt == CW'(CPB - 1) && rx_bit == 3'd7) rx_next = R_STOP;
            R_STOP: begin
                if (rx_cnt == CW'(CPB - 1)) begin
                    rx_next = R_IDLE;
                    rx_done = rx_sync;
                    rx_ferr = !rx_sync;
                end
            end
            default: rx_next = R_IDLE;
        endcase
    end

    // RX bit timer and LSB-first shift register
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_byte <= '0;
        end else begin
            if (rx_state == R_IDLE || rx_next != rx_state || rx_cnt == CW'(CPB - 1))
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + CW'(1);
            if (rx_state == R_START)
                rx_bit <= '0;
            if (rx_state == R_DATA && rx_cnt == CW'(CPB - 1)) begin
                rx_byte <= {rx_sync, rx_byte[7:1]};
                rx_bit  <= rx_bit + 3'd1;
            end
        end
    end

    // Frame parser: header hunt, payload collection, checksum decision
    always_comb begin
        fr_next = fr_state;
        commit  = 1'b0;
        reject  = 1'b0;
        if (rx_ferr) begin
            fr_next = F_HUNT;
            reject  = 1'b1;
        end else if (rx_done) begin
            case (fr_state)
                F_HUNT:    if (rx_byte == 8'hA5) fr_next = F_PAYLOAD;
                F_PAYLOAD: if (fr_idx == IBW'(IN_BYTES - 1)) fr_next = F_CHECK;
                F_CHECK: begin
                    fr_next = F_HUNT;
                    if (rx_byte == fr_chk) commit = 1'b1;
                    else reject = 1'b1;
                end
                default:   fr_next = F_HUNT;
            endcase
        end
    end

`ifdef VIO_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_cnt;
`endif

    // Shadow capture, output commit, status pulses and optional button release
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            fr_idx      <= '0;
            fr_chk      <= '0;
            shadow      <= '0;
            o_SWITCH    <= '0;
            o_BUTTON    <= '1;
            o_FRAME_OK  <= 1'b0;
            o_FRAME_ERR <= 1'b0;
`ifdef VIO_WATCHDOG_EN
            wdt_cnt     <= '0;
`endif
        end else begin
            o_FRAME_OK  <= commit;
            o_FRAME_ERR <= reject;
            if (rx_done && fr_state == F_HUNT) begin
                fr_idx <= '0;
                fr_chk <= '0;
            end
            if (rx_done && fr_state == F_PAYLOAD) begin
                for (int b = 0; b < IN_W; b++)
                    if (fr_idx == IBW'(b / 8)) shadow[b] <= rx_byte[b % 8];
                fr_chk <= fr_chk ^ rx_byte;
                fr_idx <= fr_idx + IBW'(1);
            end
            if (commit) begin
                o_SWITCH <= shadow[N_SW-1:0];
                o_BUTTON <= shadow[IN_W-1:N_SW];
            end
`ifdef VIO_WATCHDOG_EN
            if (commit)
                wdt_cnt <= '0;
            else if (wdt_cnt != WDT_W'(WDT_CYCLES))
                wdt_cnt <= wdt_cnt + WDT_W'(1);
            if (!commit && wdt_cnt == WDT_W'(WDT_CYCLES - 1))
                o_BUTTON <= '1;
`endif
        end
    end

    assign tx_bit_end = (tx_cnt == CW'(CPB - 1));

    // TX next state; a reply starts on a commit or from the pending flag
    always_comb begin
        tx_next  = tx_state;
        tx_begin = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (commit || pending) begin
                    tx_next  = T_START;
                    tx_begin = 1'b1;
                end
            end
            T_START: if (tx_bit_end) tx_next = T_DATA;
            T_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = T_STOP;
            T_STOP:  if (tx_bit_end) tx_next = (tx_idx == OBW'(OUT_BYTES + 1)) ? T_IDLE : T_START;
            default: tx_next = T_IDLE;
        endcase
    end

    // Reply checksum and selection of the byte following the current one
    always_comb begin
        tx_chk = '0;
        for (int i = 0; i < OUT_BYTES; i++)
            tx_chk = tx_chk ^ out_snap[8*i +: 8];
        tx_sel = tx_chk;
        for (int i = 0; i < OUT_BYTES; i++)
            if (tx_idx == OBW'(i)) tx_sel = out_snap[8*i +: 8];
    end

    // TX timer, byte sequencing, snapshot and pending coalescing
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_idx   <= '0;
            tx_shift <= 8'hFF;
            out_snap <= '0;
            pending  <= 1'b0;
        end else begin
            if (tx_state == T_IDLE || tx_bit_end)
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + CW'(1);
            if (commit && tx_state != T_IDLE)
                pending <= 1'b1;
            else if (tx_begin)
                pending <= 1'b0;
            if (tx_begin) begin
                out_snap <= (OUT_BYTES*8)'({i_7S, i_LEDS});
                tx_shift <= 8'h5A;
                tx_idx   <= '0;
            end
            if (tx_state == T_START)
                tx_bit <= '0;
            if (tx_state == T_DATA && tx_bit_end) begin
                tx_shift <= {1'b1, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
            if (tx_state == T_STOP && tx_bit_end && tx_idx != OBW'(OUT_BYTES + 1)) begin
                tx_shift <= tx_sel;
                tx_idx   <= tx_idx + OBW'(1);
            end
        end
    end

    // Line level decoded from the TX state; idle and stop are high
    always_comb begin
        o_TX = 1'b1;
        if (tx_state == T_START)
            o_TX = 1'b0;
        else if (tx_state == T_DATA)
            o_TX = tx_shift[0];
    end
endmodule

// File: tb/tb_uart_vio_bridge.sv
// tb/tb_uart_vio_bridge.sv - directed self-checking bench for uart_vio_bridge
module tb_uart_vio_bridge;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic tx;
    logic [9:0] leds = 10'h155;
    logic [41:0] segs = '1;
    logic [9:0] sw;
    logic [3:0] btn;
    logic fok, ferr;

    int n_checks = 0;
    int n_fail = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int stop_err = 0;
    logic [7:0] txq[$];

    logic [7:0] exp1 [9] = '{8'h5A, 8'h55, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'hA7};
    logic [7:0] exp2 [9] = '{8'h5A, 8'hAA, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h59};

    always #5 clk = ~clk;

    uart_vio_bridge #(
        .baud(100000), .clock(1000000), .WDT_CYCLES(1000)
    ) dut (
        .i_CLK(clk), .i_RST(rst), .i_RX(rx), .o_TX(tx),
        .i_LEDS(leds), .i_7S(segs),
        .o_SWITCH(sw), .o_BUTTON(btn),
        .o_FRAME_OK(fok), .o_FRAME_ERR(ferr)
    );

    // Count status pulse cycles
    always @(negedge clk) begin
        if (fok) ok_cnt++;
        if (ferr) err_cnt++;
    end

    // Decode bytes from the TX line into a queue
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) stop_err++;
                txq.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (txq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("tx_byte_count", txq.size(), n);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_switch", sw, 10'h000);
        check("reset_button", btn, 4'hF);
        check("reset_tx", tx, 1'b1);
        check("reset_ok", ok_cnt, 0);

        // Valid frame and full reply
        send_frame(8'hA5, 8'hFF, 8'h3F, 8'hC0);
        check("valid_switch", sw, 10'h3FF);
        check("valid_button", btn, 4'hF);
        check("valid_ok_pulse", ok_cnt, 1);
        check("valid_no_err", err_cnt, 0);
        wait_tx(9, 2000);
        for (int i = 0; i < 9; i++)
            if (i < txq.size()) check($sformatf("reply1_byte%0d", i), txq[i], exp1[i]);
        repeat (20) @(negedge clk);
        txq.delete();

        // Bad checksum
        send_frame(8'hA5, 8'h12, 8'h00, 8'h00);
        check("badchk_switch", sw, 10'h3FF);
        check("badchk_button", btn, 4'hF);
        check("badchk_err_pulse", err_cnt, 1);
        check("badchk_no_ok", ok_cnt, 1);
        repeat (200) @(negedge clk);
        check("badchk_no_tx", txq.size(), 0);
        check("badchk_tx_idle", tx, 1'b1);

        // Resync with data byte equal to header
        send_byte(8'h33, 1'b1);
        send_frame(8'hA5, 8'hA5, 8'h00, 8'hA5);
        check("resync_switch", sw, 10'h0A5);
        check("resync_button", btn, 4'h0);
        check("resync_ok", ok_cnt, 2);
        wait_tx(9, 2000);
        repeat (20) @(negedge clk);
        txq.delete();

        // Framing error inside payload, then recovery
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b0);
        check("ferr_err_pulse", err_cnt, 2);
        check("ferr_switch_held", sw, 10'h0A5);
        send_frame(8'hA5, 8'h01, 8'h02, 8'h03);
        check("ferr_recover_switch", sw, 10'h201);
        check("ferr_recover_button", btn, 4'h0);
        check("ferr_recover_ok", ok_cnt, 3);
        wait_tx(9, 2000);
        repeat (20) @(negedge clk);
        txq.delete();

        // Back-to-back frames coalesce into one extra reply
        leds = 10'h155;
        send_frame(8'hA5, 8'hFF, 8'h3F, 8'hC0);
        send_frame(8'hA5, 8'h01, 8'h02, 8'h03);
        send_frame(8'hA5, 8'hA5, 8'h00, 8'hA5);
        leds = 10'h0AA;
        check("b2b_switch", sw, 10'h0A5);
        check("b2b_ok", ok_cnt, 6);
        wait_tx(18, 3000);
        for (int i = 0; i < 9; i++)
            if (i < txq.size()) check($sformatf("b2b_reply1_byte%0d", i), txq[i], exp1[i]);
        for (int i = 0; i < 9; i++)
            if (i + 9 < txq.size()) check($sformatf("b2b_reply2_byte%0d", i), txq[i+9], exp2[i]);
        repeat (1500) @(negedge clk);
        check("b2b_exactly_two_replies", txq.size(), 18);
        txq.delete();

        // Button hold or watchdog release after a quiet period
        send_frame(8'hA5, 8'h00, 8'h00, 8'h00);
        check("quiet_switch", sw, 10'h000);
        check("quiet_button", btn, 4'h0);
        repeat (990) @(negedge clk);
        check("quiet_button_early", btn, 4'h0);
        repeat (15) @(negedge clk);
`ifdef VIO_WATCHDOG_EN
        check("wdt_button_released", btn, 4'hF);
`else
        check("hold_button", btn, 4'h0);
`endif
        check("quiet_switch_held", sw, 10'h000);
        check("tx_stop_bits", stop_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
